// File: rtl/acc_resp_unit_if.sv
// ACC_BUS request (Q) / response (P) channel bundle.
// The master side issues requests and accepts responses; the slave side is the accelerator.
interface acc_resp_unit_if #(
    parameter int unsigned DataWidth = 32,
    parameter int unsigned AddrWidth = 2,
    parameter int unsigned IdWidth   = 4
);
    // Q channel: offloaded instruction plus operands
    logic [AddrWidth-1:0] q_addr;
    logic [31:0]          q_data_op;
    logic [DataWidth-1:0] q_data_arga;
    logic [DataWidth-1:0] q_data_argb;
    logic [DataWidth-1:0] q_data_argc;
    logic [IdWidth-1:0]   q_id;
    logic                 q_valid;
    logic                 q_ready;

    // P channel: in-order results
    logic [DataWidth-1:0] p_data0;
    logic [DataWidth-1:0] p_data1;
    logic                 p_dual_writeback;
    logic [IdWidth-1:0]   p_id;
    logic [4:0]           p_rd;
    logic                 p_error;
    logic                 p_valid;
    logic                 p_ready;

    modport master (
        output q_addr, q_data_op, q_data_arga, q_data_argb, q_data_argc, q_id, q_valid,
        input  q_ready,
        input  p_data0, p_data1, p_dual_writeback, p_id, p_rd, p_error, p_valid,
        output p_ready
    );

    modport slave (
        input  q_addr, q_data_op, q_data_arga, q_data_argb, q_data_argc, q_id, q_valid,
        output q_ready,
        output p_data0, p_data1, p_dual_writeback, p_id, p_rd, p_error, p_valid,
        input  p_ready
    );
endinterface

// File: rtl/acc_resp_unit.sv
// Reference accelerator on the ACC_BUS responder end.
// Decodes custom-0 instructions, runs them through a fixed-latency pipeline and
// returns results in order from a response FIFO. An outstanding-request counter
// guards Q so that pipeline plus FIFO can never hold more than RspDepth entries.
module acc_resp_unit #(
    parameter int unsigned DataWidth = 32,
    parameter int unsigned AddrWidth = 2,
    parameter int unsigned AccAddr   = 0,
    parameter int unsigned IdWidth   = 4,
    parameter int unsigned Latency   = 2,
    parameter int unsigned RspDepth  = 4
) (
    input logic            clk_i,
    input logic            rst_ni,
    acc_resp_unit_if.slave bus
);
    localparam int unsigned CntW = $clog2(RspDepth + 1);
    localparam int unsigned PtrW = (RspDepth > 1) ? $clog2(RspDepth) : 1;
    localparam logic [CntW-1:0]      DepthC   = CntW'(RspDepth);
    localparam logic [PtrW-1:0]      PtrLast  = PtrW'(RspDepth - 1);
    localparam logic [AddrWidth-1:0] AccAddrC = AddrWidth'(AccAddr);
    localparam logic [6:0]           OpCustom0 = 7'b0001011;

    typedef struct packed {
        logic [DataWidth-1:0] data;
        logic [IdWidth-1:0]   id;
        logic [4:0]           rd;
        logic                 err;
    } rsp_t;

    logic                 w_q_fire;
    logic                 w_p_fire;
    logic                 w_push;
    logic                 w_legal;
    logic                 w_op_ok;
    logic [DataWidth-1:0] w_mul;
    logic [DataWidth-1:0] w_res;
    rsp_t                 w_new;
    rsp_t                 w_head;
    logic                 w_unused_op;

    logic [CntW-1:0]      r_cnt;
    logic [Latency-1:0]   r_pipe_vld;
    rsp_t                 r_pipe [Latency];
    rsp_t                 r_mem  [RspDepth];
    logic [PtrW-1:0]      r_wptr;
    logic [PtrW-1:0]      r_rptr;
    logic [CntW-1:0]      r_fcnt;

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] ptr);
        return (ptr == PtrLast) ? '0 : ptr + PtrW'(1);
    endfunction

    // Q is gated by registered occupancy only, so q_ready never looks at q_valid.
    assign bus.q_ready = rst_ni && (r_cnt < DepthC);
    assign w_q_fire    = bus.q_valid && bus.q_ready;
    assign w_p_fire    = bus.p_valid && bus.p_ready;

    // rs1/rs2 register fields carry no meaning for this unit.
    assign w_unused_op = ^bus.q_data_op[24:15];

    assign w_legal = (bus.q_addr == AccAddrC) && (bus.q_data_op[6:0] == OpCustom0) &&
                     (bus.q_data_op[31:25] == 7'd0);
    assign w_mul   = bus.q_data_arga * bus.q_data_argb;

    // Decode funct3 and compute the result; illegal requests carry a zero result.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        w_res   = '0;
        w_op_ok = 1'b1;
        case (bus.q_data_op[14:12])
            3'b000:  w_res = bus.q_data_arga + bus.q_data_argb + bus.q_data_argc;
            3'b001:  w_res = w_mul + bus.q_data_argc;
            3'b010:  w_res = (bus.q_data_arga > bus.q_data_argb) ? bus.q_data_arga
                                                                 : bus.q_data_argb;
            3'b011:  w_res = bus.q_data_arga - bus.q_data_argb;
            default: w_op_ok = 1'b0;
        endcase
        w_new.err  = !(w_legal && w_op_ok);
        w_new.data = w_new.err ? '0 : w_res;
        w_new.id   = bus.q_id;
        w_new.rd   = bus.q_data_op[11:7];
    end

    // Outstanding counter: accepted minus answered requests.
    always_ff @(posedge clk_i) begin
        // NOTE: state registers use non-blocking assignments so every block sees pre-edge values.
        if (!rst_ni) begin
            r_cnt <= '0;
        end else begin
            case ({w_q_fire, w_p_fire})
                2'b10:   r_cnt <= r_cnt + CntW'(1);
                2'b01:   r_cnt <= r_cnt - CntW'(1);
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    // Pipeline valid bits; reset drops any in-flight work.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_pipe_vld <= '0;
        end else begin
            r_pipe_vld[0] <= w_q_fire;
            for (int i = 1; i < int'(Latency); i++) begin
                r_pipe_vld[i] <= r_pipe_vld[i-1];
            end
        end
    end

    // Pipeline payload, qualified by r_pipe_vld.
    always_ff @(posedge clk_i) begin
        r_pipe[0] <= w_new;
        for (int i = 1; i < int'(Latency); i++) begin
            r_pipe[i] <= r_pipe[i-1];
        end
    end

    assign w_push = r_pipe_vld[Latency-1];

    // Response FIFO pointers and fill level.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_wptr <= '0;
            r_rptr <= '0;
            r_fcnt <= '0;
        end else begin
            if (w_push) r_wptr <= ptr_inc(r_wptr);
            if (w_p_fire) r_rptr <= ptr_inc(r_rptr);
            case ({w_push, w_p_fire})
                2'b10:   r_fcnt <= r_fcnt + CntW'(1);
                2'b01:   r_fcnt <= r_fcnt - CntW'(1);
                default: r_fcnt <= r_fcnt;
            endcase
        end
    end

    // Response FIFO storage.
    always_ff @(posedge clk_i) begin
        // NOTE: storage is not reset; r_fcnt says which entries are meaningful.
        if (w_push) r_mem[r_wptr] <= r_pipe[Latency-1];
    end

    assign w_head               = r_mem[r_rptr];
    assign bus.p_valid          = rst_ni && (r_fcnt != '0);
    assign bus.p_data0          = rst_ni ? w_head.data : '0;
    assign bus.p_id             = rst_ni ? w_head.id   : '0;
    assign bus.p_rd             = rst_ni ? w_head.rd   : '0;
    assign bus.p_error          = rst_ni ? w_head.err  : 1'b0;
    assign bus.p_data1          = '0;
    assign bus.p_dual_writeback = 1'b0;

    a_no_push_full: assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(w_push && (r_fcnt == DepthC)));
    a_no_pop_empty: assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(w_p_fire && (r_fcnt == '0)));
endmodule

// File: tb/tb_acc_resp_unit.sv
// Self-checking bench for acc_resp_unit: directed scenarios plus random traffic,
// checked every cycle against a queue-based reference of outstanding responses.
module tb_acc_resp_unit;
    localparam int LAT   = 2;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic rst_ni;
    always #5 clk = ~clk;

    acc_resp_unit_if #(.DataWidth(32), .AddrWidth(2), .IdWidth(4)) bus ();

    acc_resp_unit #(
        .DataWidth(32), .AddrWidth(2), .AccAddr(0), .IdWidth(4),
        .Latency(LAT), .RspDepth(DEPTH)
    ) dut (
        .clk_i (clk),
        .rst_ni(rst_ni),
        .bus   (bus)
    );

    typedef struct {
        logic [31:0] data;
        logic [3:0]  id;
        logic [4:0]  rd;
        logic        err;
        int unsigned due;
    } rsp_t;

    rsp_t        exp_q[$];
    rsp_t        got_q[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    int unsigned edge_n   = 0;
    logic        last_hs_q;
    logic        s_q_ready;
    logic        s_p_valid;
    rsp_t        s_rsp;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Expected response straight from the instruction semantics.
    function automatic rsp_t model(input logic [1:0] addr, input logic [31:0] op,
                                   input logic [31:0] a, input logic [31:0] b,
                                   input logic [31:0] c, input logic [3:0] id);
        rsp_t r;
        logic legal;
        r.id   = id;
        r.rd   = op[11:7];
        r.data = 32'd0;
        r.due  = 0;
        legal  = (addr == 2'd0) && (op[6:0] == 7'b0001011) && (op[31:25] == 7'd0);
        case (op[14:12])
            3'd0:    r.data = a + b + c;
            3'd1:    r.data = a * b + c;
            3'd2:    r.data = (a > b) ? a : b;
            3'd3:    r.data = a - b;
            default: legal = 1'b0;
        endcase
        r.err = !legal;
        if (!legal) r.data = 32'd0;
        return r;
    endfunction

    function automatic logic [31:0] mk_op(input logic [6:0] f7, input logic [2:0] f3,
                                          input logic [4:0] rd);
        return {f7, 10'd0, f3, rd, 7'b0001011};
    endfunction

    // One clock: compare outputs mid-cycle, then apply the edge to the reference.
    task automatic tick();
        logic rst_s, hs_q, hs_p, exp_pv;
        rsp_t req;
        @(negedge clk);
        rst_s      = rst_ni;
        s_q_ready  = bus.q_ready;
        s_p_valid  = bus.p_valid;
        s_rsp.data = bus.p_data0;
        s_rsp.id   = bus.p_id;
        s_rsp.rd   = bus.p_rd;
        s_rsp.err  = bus.p_error;
        s_rsp.due  = 0;
        check("p_data1", bus.p_data1, 0);
        check("p_dual_wb", bus.p_dual_writeback, 0);
        if (!rst_s) begin
            check("rst_q_ready", s_q_ready, 0);
            check("rst_p_valid", s_p_valid, 0);
            check("rst_p_data0", s_rsp.data, 0);
            check("rst_p_id", s_rsp.id, 0);
            check("rst_p_rd", s_rsp.rd, 0);
            check("rst_p_error", s_rsp.err, 0);
        end else begin
            check("q_ready", s_q_ready, (exp_q.size() < DEPTH));
            exp_pv = 1'b0;
            if (exp_q.size() > 0) exp_pv = (exp_q[0].due <= edge_n);
            check("p_valid", s_p_valid, exp_pv);
            if (s_p_valid && exp_pv) begin
                check("p_data0", s_rsp.data, exp_q[0].data);
                check("p_id", s_rsp.id, exp_q[0].id);
                check("p_rd", s_rsp.rd, exp_q[0].rd);
                check("p_error", s_rsp.err, exp_q[0].err);
            end
        end
        hs_q = rst_s && bus.q_valid && s_q_ready;
        hs_p = rst_s && s_p_valid && bus.p_ready;
        req  = model(bus.q_addr, bus.q_data_op, bus.q_data_arga, bus.q_data_argb,
                     bus.q_data_argc, bus.q_id);
        @(posedge clk);
        edge_n++;
        if (!rst_s) begin
            exp_q.delete();
        end else begin
            if (hs_p) begin
                if (exp_q.size() > 0) void'(exp_q.pop_front());
                got_q.push_back(s_rsp);
            end
            if (hs_q) begin
                req.due = edge_n + LAT;
                exp_q.push_back(req);
            end
        end
        last_hs_q = hs_q;
        #1;
    endtask

    task automatic set_req(input logic [1:0] addr, input logic [31:0] op, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] c, input logic [3:0] id);
        bus.q_addr      = addr;
        bus.q_data_op   = op;
        bus.q_data_arga = a;
        bus.q_data_argb = b;
        bus.q_data_argc = c;
        bus.q_id        = id;
        bus.q_valid     = 1'b1;
    endtask

    task automatic send(input logic [1:0] addr, input logic [31:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] c, input logic [3:0] id);
        set_req(addr, op, a, b, c, id);
        for (int n = 0; n < 50; n++) begin
            tick();
            if (last_hs_q) break;
        end
        if (!last_hs_q) check("send_timeout", 0, 1);
        bus.q_valid = 1'b0;
    endtask

    task automatic drain();
        bus.q_valid = 1'b0;
        bus.p_ready = 1'b1;
        for (int n = 0; n < 100 && exp_q.size() > 0; n++) tick();
        check("drain_empty", exp_q.size(), 0);
    endtask

    function automatic logic [31:0] rand_arg();
        case ($urandom_range(0, 3))
            0:       return 32'hFFFF_FFFF;
            1:       return 32'($urandom_range(0, 15));
            default: return $urandom;
        endcase
    endfunction

    task automatic drive_rand(input bit legal_only);
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [1:0]  addr;
        logic [31:0] op;
        f3   = legal_only ? 3'($urandom_range(0, 3)) : 3'($urandom_range(0, 7));
        f7   = (!legal_only && $urandom_range(0, 9) == 0) ? 7'($urandom) : 7'd0;
        addr = (!legal_only && $urandom_range(0, 9) == 0) ? 2'($urandom) : 2'd0;
        op   = {f7, 10'($urandom), f3, 5'($urandom), 7'b0001011};
        if (!legal_only && $urandom_range(0, 15) == 0) op[6:0] = 7'($urandom);
        set_req(addr, op, rand_arg(), rand_arg(), rand_arg(), 4'($urandom));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int idx, lat, stalls;
        rst_ni      = 1'b0;
        bus.p_ready = 1'b0;
        set_req(2'd0, mk_op(7'd0, 3'd0, 5'd1), 32'd1, 32'd1, 32'd1, 4'd1);

        // Reset held with a pending request: nothing accepted, nothing presented.
        repeat (3) tick();
        rst_ni      = 1'b1;
        bus.q_valid = 1'b0;
        tick();
        check("rel_q_ready", s_q_ready, 1);

        // Single ADD3 with wrap-around and latency measurement.
        bus.p_ready = 1'b1;
        got_q.delete();
        send(2'd0, mk_op(7'd0, 3'd0, 5'd3), 32'd5, 32'd7, 32'hFFFF_FFFF, 4'd2);
        lat = 0;
        tick();
        while (!s_p_valid && lat < 20) begin
            lat++;
            tick();
        end
        check("add3_latency", lat, LAT);
        check("add3_data", s_rsp.data, 32'hB);
        check("add3_rd", s_rsp.rd, 3);
        check("add3_id", s_rsp.id, 2);
        check("add3_err", s_rsp.err, 0);
        drain();

        // Illegal funct3, then address mismatch.
        got_q.delete();
        send(2'd0, mk_op(7'd0, 3'd7, 5'd5), 32'd1, 32'd2, 32'd3, 4'd4);
        send(2'd1, mk_op(7'd0, 3'd0, 5'd6), 32'd1, 32'd2, 32'd3, 4'd5);
        drain();
        check("err_count", got_q.size(), 2);
        if (got_q.size() == 2) begin
            check("err0_flag", got_q[0].err, 1);
            check("err0_data", got_q[0].data, 0);
            check("err0_rd", got_q[0].rd, 5);
            check("err0_id", got_q[0].id, 4);
            check("err1_flag", got_q[1].err, 1);
            check("err1_data", got_q[1].data, 0);
            check("err1_rd", got_q[1].rd, 6);
            check("err1_id", got_q[1].id, 5);
        end

        // Backpressure: six MACs against a stalled P channel.
        got_q.delete();
        bus.p_ready = 1'b0;
        idx = 0;
        for (int n = 0; n < 20; n++) begin
            set_req(2'd0, mk_op(7'd0, 3'd1, 5'(idx + 1)), 32'd3, 32'd4, 32'(idx), 4'(idx));
            tick();
            if (last_hs_q) idx++;
        end
        check("bp_accepted", idx, 4);
        check("bp_q_ready", s_q_ready, 0);
        bus.p_ready = 1'b1;
        for (int n = 0; n < 60 && idx < 6; n++) begin
            set_req(2'd0, mk_op(7'd0, 3'd1, 5'(idx + 1)), 32'd3, 32'd4, 32'(idx), 4'(idx));
            tick();
            if (last_hs_q) idx++;
        end
        drain();
        check("bp_count", got_q.size(), 6);
        foreach (got_q[i]) begin
            check("bp_data", got_q[i].data, 32'(12 + i));
            check("bp_id", got_q[i].id, 4'(i));
        end

        // Streaming: back-to-back legal ops must never stall.
        got_q.delete();
        bus.p_ready = 1'b1;
        stalls = 0;
        for (int n = 0; n < 20; n++) begin
            drive_rand(1'b1);
            tick();
            if (!last_hs_q) stalls++;
        end
        drain();
        check("stream_stalls", stalls, 0);
        check("stream_count", got_q.size(), 20);

        // Random traffic with random backpressure and illegal requests.
        for (int n = 0; n < 400; n++) begin
            drive_rand(1'b0);
            bus.q_valid = ($urandom_range(0, 3) != 0);
            bus.p_ready = ($urandom_range(0, 2) != 0);
            tick();
        end
        drain();

        // Reset with three requests outstanding.
        got_q.delete();
        bus.p_ready = 1'b0;
        for (int n = 0; n < 3; n++)
            send(2'd0, mk_op(7'd0, 3'd3, 5'(n + 1)), 32'd9, 32'(n), 32'd0, 4'(n + 8));
        rst_ni = 1'b0;
        tick();
        rst_ni      = 1'b1;
        bus.p_ready = 1'b1;
        repeat (5) tick();
        check("mid_no_stale", got_q.size(), 0);
        send(2'd0, mk_op(7'd0, 3'd0, 5'd7), 32'd1, 32'd2, 32'd3, 4'd12);
        drain();
        check("mid_count", got_q.size(), 1);
        if (got_q.size() == 1) begin
            check("mid_data", got_q[0].data, 6);
            check("mid_id", got_q[0].id, 12);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
